qspi_mem_responder: RTL and testbench
=====================================

// Module: qspi_mem_responder
// PURPOSE
//  Synthesizable QPI memory responder: the far end of the cache-line fill/spill
//  link driven by the core's qspi controller. Decodes nibble-wide commands on
//  the shared 4-bit bus and services quad read / quad write bursts against a
//  local byte-wide SRAM. Used as an on-chip PSRAM/flash stand-in and bench model.
// PARAMETERS
//  AW      16  byte address bits kept (upper bits of the 24-bit bus address dropped)
//  DUMMY    6  dummy cycles between last address nibble and first read data (>=2)
//  CMD_RD  8'hEB  quad read opcode
//  CMD_WR  8'h38  quad write opcode
// PORTS
//  clk        in   1   bus clock; one nibble per rising edge while selected
//  reset      in   1   asynchronous, active-low reset
//  cs_n       in   1   chip select, active low; high ends any transaction
//  sd_in      in   4   bus nibble from controller
//  sd_out     out  4   bus nibble to controller
//  sd_oe      out  4   per-line output enable (all-or-nothing: 4'h0 or 4'hf)
//  mem_addr   out  AW  backing SRAM byte address
//  mem_wdata  out  8   backing SRAM write byte
//  mem_we     out  1   write strobe, one cycle per byte
//  mem_re     out  1   read strobe; mem_rdata valid the following cycle
//  mem_rdata  in   8   backing SRAM read byte
// BEHAVIOUR
//  Reset: state=CMD, nibble count 0, sd_out=0, sd_oe=0, mem_we=0, mem_re=0,
//   mem_addr=0, mem_wdata=0.
//  Nibble order: high nibble first for opcode, address (MSB nibble first) and data.
//  FSM (advances on clk edges with cs_n low; cs_n high -> CMD, count 0 next edge):
//   CMD   2 nibbles -> opcode. CMD_RD/CMD_WR -> ADDR; else -> IGNORE.
//   ADDR  6 nibbles (24 bits); low AW bits load addr. -> DUMMY (read) / WDATA (write).
//   DUMMY DUMMY cycles. mem_re pulsed on first dummy cycle with addr; byte latched
//         into out-buffer next cycle. -> RDATA.
//   RDATA even cycle: drive buf[7:4], pulse mem_re at addr+1 (prefetch);
//         odd cycle: drive buf[3:0], load buf from mem_rdata, addr++. Unbounded.
//   WDATA even cycle: hold sd_in as hi nibble; odd: mem_wdata={hi,sd_in},
//         mem_addr=addr, mem_we=1 for that one cycle, then addr++.
//   IGNORE outputs off until cs_n rises.
//  sd_oe=4'hf only in RDATA and gated combinationally by ~cs_n, so bus is
//   released the same cycle cs_n rises; sd_oe=0 during CMD/ADDR/DUMMY/WDATA.
//  First read nibble appears on the edge after the DUMMY-th dummy cycle:
//   read latency from opcode start = 2+6+DUMMY cycles.
//  Address wrap: addr is AW bits, AW'hFFFF+1 -> 0 (read and write alike).
//  cs_n rise mid-byte on write: partial nibble discarded, no mem_we.
//  cs_n rise mid-read: outstanding prefetch completes harmlessly, data dropped.
//  cs_n rise and mem_we same cycle: the completed byte is written.
//  Reset assertion mid-burst: immediate return to reset values, no further strobes.
// STRUCTURE
//  Shared package: state enum (CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE),
//   default opcodes, ADDR_NIBBLES=6.
//  One sub-module natural: qspi_resp_sram (AW x 8 behavioural/macro SRAM,
//   1-cycle read) instantiated in bench/top, not inside this block.
// TESTING
//  Write 0x38 @0x000010, bytes A5 3C -> mem_we twice: [0x10]=A5, [0x11]=3C.
//  Read 0xEB @0x000010, DUMMY=6 -> nibbles A,5,3,C at cycles 14..17, sd_oe=f.
//  Read @0x00FFFF (AW=16) 2 bytes with [FFFF]=11,[0000]=22 -> 1,1,2,2 (wrap).
//  Opcode 0x9F then 8 nibbles -> no mem_we/mem_re, sd_oe stays 0.
//  Write, cs_n high after 3 data nibbles -> exactly one mem_we; next CMD decodes.
//  reset low during RDATA -> sd_oe=0 and all strobes 0 immediately.

Source files
------------

// File: rtl/qspi_mem_responder_pkg.sv
// Shared types and constants for the QPI memory responder and its backing SRAM.
package qspi_mem_responder_pkg;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } state_t;

  localparam logic [7:0] CMD_RD_DEF   = 8'hEB;
  localparam logic [7:0] CMD_WR_DEF   = 8'h38;
  localparam int         ADDR_NIBBLES = 6;
  localparam int         CNT_W        = 8;

endpackage

// File: rtl/qspi_resp_sram.sv
// Byte-wide behavioural SRAM with a one-cycle registered read, used as the
// responder's backing store.
module qspi_resp_sram #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/qspi_mem_responder.sv
// QPI memory responder: decodes nibble-wide quad read/write commands and
// services unbounded bursts against an external byte-wide SRAM.
module qspi_mem_responder
  import qspi_mem_responder_pkg::*;
#(
  parameter int         AW     = 16,
  parameter int         DUMMY  = 6,
  parameter logic [7:0] CMD_RD = CMD_RD_DEF,
  parameter logic [7:0] CMD_WR = CMD_WR_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs_n,
  input  logic [3:0]    sd_in,
  output logic [3:0]    sd_out,
  output logic [3:0]    sd_oe,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [7:0]    mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_ADDR  = CNT_W'(ADDR_NIBBLES - 1);
  localparam logic [CNT_W-1:0] LAST_DUMMY = CNT_W'(DUMMY - 1);
  localparam logic [AW-1:0]    ADDR_ONE   = AW'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]    addr;
  logic [3:0]       op_hi;
  logic [3:0]       wr_hi;
  logic [3:0]       rd_lo;
  logic             is_rd;
  logic             phase;
  logic             drive;

  // The bus is released combinationally the moment cs_n rises.
  assign sd_oe = {4{drive & ~cs_n}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_CMD;
      cnt       <= '0;
      addr      <= '0;
      op_hi     <= '0;
      wr_hi     <= '0;
      rd_lo     <= '0;
      is_rd     <= 1'b0;
      phase     <= 1'b0;
      drive     <= 1'b0;
      sd_out    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      drive  <= 1'b0;
      if (cs_n) begin
        state <= ST_CMD;
        cnt   <= '0;
        phase <= 1'b0;
      end else begin
        case (state)
          ST_CMD: begin
            if (cnt == '0) begin
              op_hi <= sd_in;
              cnt   <= CNT_ONE;
            end else begin
              cnt <= '0;
              if ({op_hi, sd_in} == CMD_RD) begin
                is_rd <= 1'b1;
                state <= ST_ADDR;
              end else if ({op_hi, sd_in} == CMD_WR) begin
                is_rd <= 1'b0;
                state <= ST_ADDR;
              end else begin
                state <= ST_IGNORE;
              end
            end
          end
          // Shifting straight into addr keeps only the low AW bits of the 24-bit address.
          ST_ADDR: begin
            addr <= {addr[AW-5:0], sd_in};
            if (cnt == LAST_ADDR) begin
              cnt   <= '0;
              phase <= 1'b0;
              state <= is_rd ? ST_DUMMY : ST_WDATA;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          ST_DUMMY: begin
            if (cnt == '0) begin
              mem_re   <= 1'b1;
              mem_addr <= addr;
            end
            if (cnt == LAST_DUMMY) begin
              cnt   <= '0;
              phase <= 1'b0;
              state <= ST_RDATA;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          // Even beat consumes the fetched byte and prefetches the next one.
          ST_RDATA: begin
            drive <= 1'b1;
            phase <= ~phase;
            if (!phase) begin
              sd_out   <= mem_rdata[7:4];
              rd_lo    <= mem_rdata[3:0];
              mem_re   <= 1'b1;
              mem_addr <= addr + ADDR_ONE;
            end else begin
              sd_out <= rd_lo;
              addr   <= addr + ADDR_ONE;
            end
          end
          ST_WDATA: begin
            phase <= ~phase;
            if (!phase) begin
              wr_hi <= sd_in;
            end else begin
              mem_wdata <= {wr_hi, sd_in};
              mem_addr  <= addr;
              mem_we    <= 1'b1;
              addr      <= addr + ADDR_ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_mem_responder.sv
// Scoreboard bench for qspi_mem_responder: stimulus pushes expected writes and
// read nibbles (with their bus cycle) from a byte-array model; a monitor checks.
module tb_qspi_mem_responder;
  localparam int AW    = 16;
  localparam int DUMMY = 6;

  typedef struct {
    logic [3:0] nib;
    int         cyc;
  } rd_exp_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_exp_t;

  typedef logic [7:0] bq_t [$];

  logic          clk = 1'b0;
  logic          reset;
  logic          cs_n;
  logic [3:0]    sd_in;
  logic [3:0]    sd_out;
  logic [3:0]    sd_oe;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [7:0]    mem_rdata;

  int      n_checks = 0;
  int      n_fail   = 0;
  int      cyc      = 0;
  logic    no_re    = 1'b0;
  rd_exp_t rd_q [$];
  wr_exp_t wr_q [$];
  logic [7:0] model_mem [int];

  qspi_mem_responder #(.AW(AW), .DUMMY(DUMMY)) dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .sd_in(sd_in), .sd_out(sd_out),
    .sd_oe(sd_oe), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  qspi_resp_sram #(.AW(AW)) sram (
    .clk(clk), .we(mem_we), .re(mem_re), .addr(mem_addr),
    .wdata(mem_wdata), .rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send_nib(input logic [3:0] n);
    @(negedge clk);
    cs_n  = 1'b0;
    sd_in = n;
  endtask

  task automatic end_xfer();
    @(negedge clk);
    cs_n  = 1'b1;
    sd_in = 4'h0;
    @(negedge clk);
  endtask

  // s is the cycle number at which the first opcode nibble is sampled.
  task automatic send_hdr(input logic [7:0] op, input logic [23:0] a, output int s);
    send_nib(op[7:4]);
    s = cyc + 1;
    send_nib(op[3:0]);
    for (int i = 5; i >= 0; i--) send_nib(a[4*i +: 4]);
  endtask

  task automatic push_read_exp(input logic [23:0] a, input int n, input int s);
    logic [15:0] ad;
    logic [7:0]  b;
    rd_exp_t     e;
    for (int i = 0; i < n; i++) begin
      ad    = a[15:0] + 16'(i);
      b     = model_mem[int'(ad)];
      e.nib = b[7:4];
      e.cyc = s + 2 + 6 + DUMMY + 2 * i;
      rd_q.push_back(e);
      e.nib = b[3:0];
      e.cyc = s + 2 + 6 + DUMMY + 2 * i + 1;
      rd_q.push_back(e);
    end
  endtask

  task automatic do_write(input logic [23:0] a, input bq_t d);
    int          s;
    logic [15:0] ad;
    logic [7:0]  b;
    wr_exp_t     w;
    send_hdr(8'h38, a, s);
    for (int k = 0; k < d.size(); k++) begin
      ad = a[15:0] + 16'(k);
      model_mem[int'(ad)] = d[k];
      w.addr = ad;
      w.data = d[k];
      w.cyc  = s + 9 + 2 * k;
      wr_q.push_back(w);
    end
    for (int k = 0; k < d.size(); k++) begin
      b = d[k];
      send_nib(b[7:4]);
      send_nib(b[3:0]);
    end
    end_xfer();
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    int s;
    send_hdr(8'hEB, a, s);
    push_read_exp(a, n, s);
    repeat (DUMMY + 2 * n) send_nib(4'($urandom));
    end_xfer();
  endtask

  task automatic do_ignore();
    int s;
    no_re = 1'b1;
    send_hdr(8'h9F, 24'($urandom), s);
    repeat (2) send_nib(4'($urandom));
    end_xfer();
    no_re = 1'b0;
  endtask

  task automatic applyStimulus();
    bq_t         q;
    int          s;
    int          n;
    logic [23:0] a;
    wr_exp_t     w;

    q = {8'hA5, 8'h3C};
    do_write(24'h000010, q);
    do_read(24'h000010, 2);

    q = {8'h11, 8'h22};
    do_write(24'h00FFFF, q);
    do_read(24'h00FFFF, 2);

    do_ignore();

    // Write aborted after three data nibbles: only the first byte lands.
    send_hdr(8'h38, 24'h000020, s);
    model_mem[32'h20] = 8'h7E;
    w.addr = 16'h0020;
    w.data = 8'h7E;
    w.cyc  = s + 9;
    wr_q.push_back(w);
    send_nib(4'h7);
    send_nib(4'hE);
    send_nib(4'h9);
    end_xfer();
    do_read(24'h000020, 1);

    // Reset asserted while a read burst is driving the bus.
    send_hdr(8'hEB, 24'h000010, s);
    push_read_exp(24'h000010, 2, s);
    repeat (DUMMY + 1) send_nib(4'h0);
    @(posedge clk);
    #3;
    check("pre_reset_oe", 32'(sd_oe), 32'hf);
    check("pre_reset_re", 32'(mem_re), 32'h1);
    reset = 1'b0;
    #1;
    check("reset_oe", 32'(sd_oe), 32'h0);
    check("reset_re", 32'(mem_re), 32'h0);
    check("reset_we", 32'(mem_we), 32'h0);
    check("reset_sd_out", 32'(sd_out), 32'h0);
    check("reset_mem_addr", 32'(mem_addr), 32'h0);
    rd_q.delete();
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int it = 0; it < 16; it++) begin
      a = 24'($urandom);
      if ($urandom_range(0, 3) == 0) a[15:0] = 16'hFFFF - 16'($urandom_range(0, 3));
      n = $urandom_range(1, 6);
      q = {};
      for (int k = 0; k < n; k++) q.push_back(8'($urandom));
      do_write(a, q);
      do_read(a, $urandom_range(1, n));
      if ($urandom_range(0, 3) == 0) do_ignore();
    end
  endtask

  task automatic checkOutput();
    rd_exp_t e;
    wr_exp_t w;
    forever begin
      @(posedge clk);
      #2;
      if (rd_q.size() == 0) begin
        check("unexpected_oe", 32'(sd_oe), 32'h0);
      end else if (rd_q[0].cyc <= cyc) begin
        e = rd_q.pop_front();
        check("rd_oe", 32'(sd_oe), 32'hf);
        check("rd_nibble", 32'(sd_out), 32'(e.nib));
      end else begin
        check("early_oe", 32'(sd_oe), 32'h0);
      end
      if (wr_q.size() == 0) begin
        check("unexpected_we", 32'(mem_we), 32'h0);
      end else if (wr_q[0].cyc <= cyc) begin
        w = wr_q.pop_front();
        check("wr_strobe", 32'(mem_we), 32'h1);
        check("wr_addr", 32'(mem_addr), 32'(w.addr));
        check("wr_data", 32'(mem_wdata), 32'(w.data));
      end else begin
        check("early_we", 32'(mem_we), 32'h0);
      end
      if (no_re) check("ignore_re", 32'(mem_re), 32'h0);
    end
  endtask

  initial checkOutput();

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    cs_n  = 1'b1;
    sd_in = 4'h0;
    repeat (2) @(negedge clk);
    check("init_sd_out", 32'(sd_out), 32'h0);
    check("init_sd_oe", 32'(sd_oe), 32'h0);
    check("init_mem_we", 32'(mem_we), 32'h0);
    check("init_mem_re", 32'(mem_re), 32'h0);
    check("init_mem_addr", 32'(mem_addr), 32'h0);
    check("init_mem_wdata", 32'(mem_wdata), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    applyStimulus();
    repeat (4) @(negedge clk);
    check("rd_q_drained", 32'(rd_q.size()), 32'h0);
    check("wr_q_drained", 32'(wr_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
